// File: rtl/image_streamer_pkg.sv
// Shared types and constants for the image streamer.
package image_streamer_pkg;

  localparam int unsigned IMG_DIM     = 28;
  localparam int unsigned PIX_PER_IMG = IMG_DIM * IMG_DIM;
  localparam int unsigned PIX_CNT_W   = 10;
  localparam int unsigned IDX_W       = 8;
  localparam int unsigned DIGIT_W     = 4;
  localparam int unsigned PIX_W       = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_STREAM   = 3'd1,
    ST_DRAIN    = 3'd2,
    ST_WAIT_RES = 3'd3,
    ST_REPORT   = 3'd4
  } state_t;

  // Bits needed to count from 0 up to max_val (at least one bit).
  function automatic int unsigned ctr_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/image_streamer_stream_timeout_ctr.sv
// Up-counter with synchronous load, count enable and terminal-count flag.
module stream_timeout_ctr #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         tc_c
);

  logic [W-1:0] count;

  // Load has priority over counting; reset is synchronous active-low.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  assign tc_c = (count == term);

endmodule

// File: rtl/image_streamer.sv
// Streams NUM_IMAGES 28x28 images from memory to a CNN and collects one
// classified digit per image, with a per-image response timeout.
module image_streamer
  import image_streamer_pkg::*;
#(
  parameter int unsigned NUM_IMAGES     = 10,
  parameter int unsigned PIX_GAP        = 0,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned ADDR_W         = 13
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               img_rd_en,
  output logic [ADDR_W-1:0]  img_rd_addr,
  input  logic [PIX_W-1:0]   img_rd_data,
  output logic [PIX_W-1:0]   pixel_o,
  output logic               pixel_o_valid,
  input  logic [DIGIT_W-1:0] digit_i,
  input  logic               digit_i_valid,
  output logic [DIGIT_W-1:0] result_digit,
  output logic [IDX_W-1:0]   result_idx,
  output logic               result_valid,
  output logic               busy,
  output logic               done,
  output logic               timeout_err
);

  localparam int unsigned PACE_W = ctr_width(PIX_GAP);
  localparam int unsigned TO_W   = ctr_width(TIMEOUT_CYCLES - 1);

  state_t state;
  state_t next_state;

  logic [PIX_CNT_W-1:0] pix_cnt;
  logic [PIX_CNT_W-1:0] pix_cnt_d;
  logic [IDX_W-1:0]     img_idx;
  logic [IDX_W-1:0]     img_idx_d;

  logic                 rd_en_d;
  logic [ADDR_W-1:0]    rd_addr_d;
  logic                 result_valid_d;
  logic [DIGIT_W-1:0]   result_digit_d;
  logic [IDX_W-1:0]     result_idx_d;
  logic                 done_d;
  logic                 timeout_err_d;
  logic                 busy_d;

  logic                 pace_load;
  logic                 pace_en;
  logic                 pace_tc_c;
  logic                 to_load;
  logic                 to_en;
  logic                 to_tc_c;

  logic                 img_done_c;
  logic                 last_img_c;

  assign img_done_c = (pix_cnt == PIX_CNT_W'(PIX_PER_IMG));
  assign last_img_c = (img_idx == IDX_W'(NUM_IMAGES - 1));

  // Paces reads: terminal count marks the cycle a new read may be issued.
  stream_timeout_ctr #(
    .W (PACE_W)
  ) u_pace_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (pace_load),
    .load_val ('0),
    .en       (pace_en),
    .term     (PACE_W'(PIX_GAP)),
    .tc_c     (pace_tc_c)
  );

  // Counts WAIT_RES cycles; terminal count is the last cycle before timeout.
  stream_timeout_ctr #(
    .W (TO_W)
  ) u_timeout_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (to_load),
    .load_val ('0),
    .en       (to_en),
    .term     (TO_W'(TIMEOUT_CYCLES - 1)),
    .tc_c     (to_tc_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE: begin
        if (start) next_state = ST_STREAM;
      end
      ST_STREAM: begin
        if (img_done_c) next_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        next_state = ST_WAIT_RES;
      end
      ST_WAIT_RES: begin
        if (digit_i_valid) begin
          next_state = ST_REPORT;
        end else if (to_tc_c) begin
          next_state = ST_IDLE;
        end
      end
      ST_REPORT: begin
        next_state = last_img_c ? ST_IDLE : ST_STREAM;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, datapath and counter controls.
  always_comb begin
    rd_en_d        = 1'b0;
    rd_addr_d      = img_rd_addr;
    pix_cnt_d      = pix_cnt;
    img_idx_d      = img_idx;
    result_valid_d = 1'b0;
    result_digit_d = result_digit;
    result_idx_d   = result_idx;
    done_d         = 1'b0;
    timeout_err_d  = timeout_err;
    busy_d         = (next_state != ST_IDLE);
    pace_load      = 1'b0;
    pace_en        = 1'b0;
    to_load        = 1'b0;
    to_en          = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          rd_en_d       = 1'b1;
          rd_addr_d     = '0;
          pix_cnt_d     = PIX_CNT_W'(1);
          img_idx_d     = '0;
          timeout_err_d = 1'b0;
          pace_load     = 1'b1;
        end
      end
      ST_STREAM: begin
        if (!img_done_c) begin
          if (pace_tc_c) begin
            rd_en_d   = 1'b1;
            rd_addr_d = img_rd_addr + ADDR_W'(1);
            pix_cnt_d = pix_cnt + PIX_CNT_W'(1);
            pace_load = 1'b1;
          end else begin
            pace_en = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        to_load = 1'b1;
      end
      ST_WAIT_RES: begin
        if (digit_i_valid) begin
          result_valid_d = 1'b1;
          result_digit_d = digit_i;
          result_idx_d   = img_idx;
          done_d         = last_img_c;
        end else if (to_tc_c) begin
          done_d        = 1'b1;
          timeout_err_d = 1'b1;
        end else begin
          to_en = 1'b1;
        end
      end
      ST_REPORT: begin
        // Next image continues from the address after the last pixel read.
        if (!last_img_c) begin
          rd_en_d   = 1'b1;
          rd_addr_d = img_rd_addr + ADDR_W'(1);
          pix_cnt_d = PIX_CNT_W'(1);
          img_idx_d = img_idx + IDX_W'(1);
          pace_load = 1'b1;
        end
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      img_rd_en     <= 1'b0;
      img_rd_addr   <= '0;
      pix_cnt       <= '0;
      img_idx       <= '0;
      pixel_o_valid <= 1'b0;
      result_valid  <= 1'b0;
      result_digit  <= '0;
      result_idx    <= '0;
      done          <= 1'b0;
      timeout_err   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      img_rd_en     <= rd_en_d;
      img_rd_addr   <= rd_addr_d;
      pix_cnt       <= pix_cnt_d;
      img_idx       <= img_idx_d;
      pixel_o_valid <= img_rd_en;
      result_valid  <= result_valid_d;
      result_digit  <= result_digit_d;
      result_idx    <= result_idx_d;
      done          <= done_d;
      timeout_err   <= timeout_err_d;
      busy          <= busy_d;
    end
  end

  // Memory data arrives one cycle after the read, in step with pixel_o_valid.
  assign pixel_o = pixel_o_valid ? img_rd_data : '0;

endmodule

// File: tb/tb_image_streamer.sv
// Directed bench: two streamer instances (back-to-back and gapped/timeout).
module tb_image_streamer;

  logic clk;
  logic rst;
  logic mon_clr;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fails = 0;

  // Instance A: 2 images, no gap, generous timeout.
  logic        a_start, a_rd_en, a_pixel_valid, a_digit_valid;
  logic [12:0] a_rd_addr;
  logic [7:0]  a_rd_data, a_pixel, a_res_idx;
  logic [3:0]  a_digit, a_res_digit;
  logic        a_res_valid, a_busy, a_done, a_terr;

  // Instance B: 1 image, gap of 2, timeout of 50.
  logic        b_start, b_rd_en, b_pixel_valid, b_digit_valid;
  logic [12:0] b_rd_addr;
  logic [7:0]  b_rd_data, b_pixel, b_res_idx;
  logic [3:0]  b_digit, b_res_digit;
  logic        b_res_valid, b_busy, b_done, b_terr;

  image_streamer #(.NUM_IMAGES(2), .PIX_GAP(0), .TIMEOUT_CYCLES(200), .ADDR_W(13)) u_a (
    .clk(clk), .rst(rst), .start(a_start),
    .img_rd_en(a_rd_en), .img_rd_addr(a_rd_addr), .img_rd_data(a_rd_data),
    .pixel_o(a_pixel), .pixel_o_valid(a_pixel_valid),
    .digit_i(a_digit), .digit_i_valid(a_digit_valid),
    .result_digit(a_res_digit), .result_idx(a_res_idx), .result_valid(a_res_valid),
    .busy(a_busy), .done(a_done), .timeout_err(a_terr)
  );

  image_streamer #(.NUM_IMAGES(1), .PIX_GAP(2), .TIMEOUT_CYCLES(50), .ADDR_W(13)) u_b (
    .clk(clk), .rst(rst), .start(b_start),
    .img_rd_en(b_rd_en), .img_rd_addr(b_rd_addr), .img_rd_data(b_rd_data),
    .pixel_o(b_pixel), .pixel_o_valid(b_pixel_valid),
    .digit_i(b_digit), .digit_i_valid(b_digit_valid),
    .result_digit(b_res_digit), .result_idx(b_res_idx), .result_valid(b_res_valid),
    .busy(b_busy), .done(b_done), .timeout_err(b_terr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memories: contents are the low byte of the address, one-cycle latency.
  always @(posedge clk) if (a_rd_en) a_rd_data <= a_rd_addr[7:0];
  always @(posedge clk) if (b_rd_en) b_rd_data <= b_rd_addr[7:0];

  // Monitor A.
  int a_pix_seen, a_pix_bad, a_addr_exp, a_addr_bad, a_run, a_done_cnt, a_done_res;
  int a_runs[$];
  logic [11:0] a_res[$];
  always @(negedge clk) begin
    if (mon_clr) begin
      a_pix_seen = 0; a_pix_bad = 0; a_addr_exp = 0; a_addr_bad = 0;
      a_run = 0; a_done_cnt = 0; a_done_res = 0;
      a_runs.delete(); a_res.delete();
    end else begin
      if (a_rd_en) begin
        if (a_rd_addr != 13'(a_addr_exp)) a_addr_bad++;
        a_addr_exp++;
      end
      if (a_pixel_valid) begin
        if (a_pixel != 8'(a_pix_seen)) a_pix_bad++;
        a_pix_seen++;
        a_run++;
      end else if (a_run != 0) begin
        a_runs.push_back(a_run);
        a_run = 0;
      end
      if (a_res_valid) a_res.push_back({a_res_idx, a_res_digit});
      if (a_done) begin
        a_done_cnt++;
        if (a_res_valid) a_done_res++;
      end
    end
  end

  // Monitor B.
  int b_pix_seen, b_pix_bad, b_addr_exp, b_addr_bad, b_gap_bad, b_res_cnt, b_done_cnt;
  int b_last_pix_cyc, b_done_cyc;
  bit b_have_last;
  always @(negedge clk) begin
    if (mon_clr) begin
      b_pix_seen = 0; b_pix_bad = 0; b_addr_exp = 0; b_addr_bad = 0; b_gap_bad = 0;
      b_res_cnt = 0; b_done_cnt = 0; b_last_pix_cyc = 0; b_done_cyc = 0; b_have_last = 0;
    end else begin
      if (b_rd_en) begin
        if (b_rd_addr != 13'(b_addr_exp)) b_addr_bad++;
        b_addr_exp++;
      end
      if (b_pixel_valid) begin
        if (b_pixel != 8'(b_pix_seen)) b_pix_bad++;
        if (b_have_last && (cyc - b_last_pix_cyc) != 3) b_gap_bad++;
        b_have_last = 1;
        b_last_pix_cyc = cyc;
        b_pix_seen++;
      end
      if (b_res_valid) b_res_cnt++;
      if (b_done) begin
        b_done_cnt++;
        b_done_cyc = cyc;
      end
    end
  end

  task automatic clear_monitors();
    mon_clr = 1'b1;
    @(negedge clk); #1;
    mon_clr = 1'b0;
  endtask

  task automatic pulse_a_start();
    a_start = 1'b1;
    @(negedge clk); #1;
    a_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({a_rd_en, a_pixel_valid, a_res_valid, a_done, a_busy, a_terr} !== 6'b0) begin
      n_fails++;
      $display("FAIL reset_a_ctrl: got %b expected 000000",
               {a_rd_en, a_pixel_valid, a_res_valid, a_done, a_busy, a_terr});
    end
    n_checks++;
    if ({a_pixel, a_res_digit, a_res_idx, a_rd_addr} !== 33'b0) begin
      n_fails++;
      $display("FAIL reset_a_data: got %h expected 0", {a_pixel, a_res_digit, a_res_idx, a_rd_addr});
    end
    n_checks++;
    if ({b_rd_en, b_pixel_valid, b_res_valid, b_done, b_busy, b_terr} !== 6'b0) begin
      n_fails++;
      $display("FAIL reset_b_ctrl: got %b expected 000000",
               {b_rd_en, b_pixel_valid, b_res_valid, b_done, b_busy, b_terr});
    end
    n_checks++;
    if ({b_pixel, b_res_digit, b_res_idx} !== 20'b0) begin
      n_fails++;
      $display("FAIL reset_b_data: got %h expected 0", {b_pixel, b_res_digit, b_res_idx});
    end
    rst = 1'b1;
    @(negedge clk); #1;
  endtask

  // Full run on A; CNN answers d0 then d1 100 cycles after each image ends.
  // Optionally injects a spurious digit and a spurious start mid-stream.
  task automatic run_a(input logic [3:0] d0, input logic [3:0] d1, input bit spurious, input string tag);
    int n;
    clear_monitors();
    pulse_a_start();
    n_checks++;
    if (a_busy !== 1'b1) begin
      n_fails++;
      $display("FAIL %s_busy: got %b expected 1", tag, a_busy);
    end
    if (spurious) begin
      n = 0;
      while (a_pix_seen < 200 && n < 1000) begin @(negedge clk); #1; n++; end
      a_digit = 4'd9; a_digit_valid = 1'b1;
      @(negedge clk); #1;
      a_digit_valid = 1'b0;
      while (a_pix_seen < 300 && n < 1000) begin @(negedge clk); #1; n++; end
      pulse_a_start();
    end
    for (int k = 0; k < 2; k++) begin
      n = 0;
      while (a_pix_seen < 784 * (k + 1) && n < 3000) begin @(negedge clk); #1; n++; end
      if (n >= 3000) begin
        n_checks++; n_fails++;
        $display("FAIL %s_wait_img%0d: got %0d pixels expected %0d", tag, k, a_pix_seen, 784 * (k + 1));
      end
      repeat (100) @(posedge clk);
      #1;
      a_digit = (k == 0) ? d0 : d1;
      a_digit_valid = 1'b1;
      @(posedge clk); #1;
      a_digit_valid = 1'b0;
    end
    n = 0;
    while (a_done_cnt < 1 && n < 500) begin @(negedge clk); #1; n++; end
    repeat (5) @(negedge clk);
    #1;
    n_checks++;
    if (a_pix_seen != 1568 || a_pix_bad != 0) begin
      n_fails++;
      $display("FAIL %s_pixels: got %0d (bad %0d) expected 1568 (bad 0)", tag, a_pix_seen, a_pix_bad);
    end
    n_checks++;
    if (a_addr_bad != 0 || a_addr_exp != 1568) begin
      n_fails++;
      $display("FAIL %s_addr: got %0d reads (bad %0d) expected 1568 (bad 0)", tag, a_addr_exp, a_addr_bad);
    end
    n_checks++;
    if (a_runs.size() != 2) begin
      n_fails++;
      $display("FAIL %s_runs: got %0d bursts expected 2", tag, a_runs.size());
    end else if (a_runs[0] != 784 || a_runs[1] != 784) begin
      n_fails++;
      $display("FAIL %s_runs: got %0d,%0d expected 784,784", tag, a_runs[0], a_runs[1]);
    end
    n_checks++;
    if (a_res.size() != 2) begin
      n_fails++;
      $display("FAIL %s_results: got %0d results expected 2", tag, a_res.size());
    end else if (a_res[0] != {8'd0, d0} || a_res[1] != {8'd1, d1}) begin
      n_fails++;
      $display("FAIL %s_results: got %h,%h expected %h,%h", tag, a_res[0], a_res[1], {8'd0, d0}, {8'd1, d1});
    end
    n_checks++;
    if (a_done_cnt != 1 || a_done_res != 1) begin
      n_fails++;
      $display("FAIL %s_done: got %0d (with result %0d) expected 1 (1)", tag, a_done_cnt, a_done_res);
    end
    n_checks++;
    if ({a_busy, a_terr, a_res_idx, a_res_digit} !== {2'b00, 8'd1, d1}) begin
      n_fails++;
      $display("FAIL %s_final: got %h expected %h", tag, {a_busy, a_terr, a_res_idx, a_res_digit}, {2'b00, 8'd1, d1});
    end
  endtask

  task automatic test_back_to_back();
    run_a(4'd7, 4'd3, 1'b0, "b2b");
  endtask

  task automatic test_spurious_inputs();
    run_a(4'd5, 4'd2, 1'b1, "spurious");
  endtask

  task automatic test_reset_mid_stream();
    int n;
    int snap;
    clear_monitors();
    pulse_a_start();
    n = 0;
    while (a_pix_seen < 400 && n < 1000) begin @(negedge clk); #1; n++; end
    rst = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if ({a_rd_en, a_pixel_valid, a_res_valid, a_done, a_busy, a_terr, a_pixel, a_rd_addr} !== 27'b0) begin
      n_fails++;
      $display("FAIL midrst_outputs: got %h expected 0",
               {a_rd_en, a_pixel_valid, a_res_valid, a_done, a_busy, a_terr, a_pixel, a_rd_addr});
    end
    rst = 1'b1;
    snap = a_pix_seen;
    repeat (20) @(negedge clk);
    #1;
    n_checks++;
    if (a_pix_seen != snap || a_res.size() != 0 || a_done_cnt != 0 || a_busy !== 1'b0) begin
      n_fails++;
      $display("FAIL midrst_quiet: got pixels %0d results %0d done %0d busy %b expected %0d 0 0 0",
               a_pix_seen, a_res.size(), a_done_cnt, a_busy, snap);
    end
    clear_monitors();
    pulse_a_start();
    repeat (30) @(negedge clk);
    #1;
    n_checks++;
    if (a_addr_bad != 0 || a_pix_bad != 0 || a_pix_seen < 25) begin
      n_fails++;
      $display("FAIL midrst_restart: got addr_bad %0d pix_bad %0d pixels %0d expected 0 0 >=25",
               a_addr_bad, a_pix_bad, a_pix_seen);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_gap_and_timeout();
    int n;
    clear_monitors();
    b_start = 1'b1;
    @(negedge clk); #1;
    b_start = 1'b0;
    n = 0;
    while (b_pix_seen < 784 && n < 3000) begin @(negedge clk); #1; n++; end
    n_checks++;
    if (b_pix_seen != 784 || b_pix_bad != 0) begin
      n_fails++;
      $display("FAIL gap_pixels: got %0d (bad %0d) expected 784 (bad 0)", b_pix_seen, b_pix_bad);
    end
    n_checks++;
    if (b_gap_bad != 0) begin
      n_fails++;
      $display("FAIL gap_spacing: got %0d bad spacings expected 0", b_gap_bad);
    end
    n_checks++;
    if (b_addr_bad != 0 || b_addr_exp != 784) begin
      n_fails++;
      $display("FAIL gap_addr: got %0d reads (bad %0d) expected 784 (bad 0)", b_addr_exp, b_addr_bad);
    end
    n = 0;
    while (b_done_cnt < 1 && n < 200) begin @(negedge clk); #1; n++; end
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (b_done_cnt != 1 || (b_done_cyc - b_last_pix_cyc) != 51) begin
      n_fails++;
      $display("FAIL timeout_done: got %0d pulses at +%0d expected 1 at +51",
               b_done_cnt, b_done_cyc - b_last_pix_cyc);
    end
    n_checks++;
    if ({b_terr, b_busy} !== 2'b10 || b_res_cnt != 0) begin
      n_fails++;
      $display("FAIL timeout_state: got err/busy %b results %0d expected 10 0", {b_terr, b_busy}, b_res_cnt);
    end
    b_start = 1'b1;
    @(negedge clk); #1;
    b_start = 1'b0;
    n_checks++;
    if ({b_terr, b_busy} !== 2'b01) begin
      n_fails++;
      $display("FAIL timeout_clear: got err/busy %b expected 01", {b_terr, b_busy});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; mon_clr = 1'b0;
    a_start = 1'b0; a_digit = '0; a_digit_valid = 1'b0;
    b_start = 1'b0; b_digit = '0; b_digit_valid = 1'b0;
    test_reset();
    test_back_to_back();
    test_spurious_inputs();
    test_reset_mid_stream();
    test_gap_and_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/image_streamer.md
IMAGE_STREAMER -- requirements
Module: image_streamer

Interface
REQ-001 Parameter NUM_IMAGES, default 10, number of 28x28 images held in the image memory.
REQ-002 Parameter PIX_GAP, default 0, idle cycles inserted between consecutive valid pixels.
REQ-003 Parameter TIMEOUT_CYCLES, default 65535, maximum wait from last pixel to digit_i_valid.
REQ-004 Parameter ADDR_W, default 13, image memory address width; must satisfy 2^ADDR_W >= NUM_IMAGES*784.
REQ-005 clk  input  1  single clock; all logic rising-edge.
REQ-006 rst  input  1  synchronous, active-low reset.
REQ-007 start  input  1  one-cycle pulse; begins a run over all images.
REQ-008 img_rd_en  output  1  image memory read enable.
REQ-009 img_rd_addr  output  ADDR_W  image memory address = image*784 + pixel.
REQ-010 img_rd_data  input  8  read data, valid exactly 1 cycle after img_rd_en.
REQ-011 pixel_o  output  8  pixel to CNN pixel_i.
REQ-012 pixel_o_valid  output  1  qualifies pixel_o; drives CNN pixel_i_valid.
REQ-013 digit_i  input  4  classification from CNN digit_o.
REQ-014 digit_i_valid  input  1  qualifies digit_i.
REQ-015 result_digit  output  4  captured classification.
REQ-016 result_idx  output  8  image index of result_digit.
REQ-017 result_valid  output  1  one-cycle pulse with result_digit/result_idx.
REQ-018 busy  output  1  high in any state except IDLE.
REQ-019 done  output  1  one-cycle pulse when run completes (success or timeout).
REQ-020 timeout_err  output  1  sticky; set on timeout, cleared by next accepted start.

Function
REQ-021 States: IDLE, STREAM, DRAIN, WAIT_RES, REPORT; encoding from shared package.
REQ-022 IDLE: start=1 -> STREAM, image index=0, pixel counter=0, timeout_err cleared; start in other states ignored.
REQ-023 STREAM: issue img_rd_en once every PIX_GAP+1 cycles, address incrementing by 1; after 784th read -> DRAIN.
REQ-024 pixel_o_valid asserted exactly 1 cycle after each img_rd_en, pixel_o=img_rd_data; exactly 784 valid pixels per image, row-major order.
REQ-025 DRAIN: one cycle to emit final pixel, then WAIT_RES with timeout counter=0.
REQ-026 WAIT_RES: digit_i_valid=1 -> capture digit_i, -> REPORT; counter reaching TIMEOUT_CYCLES -> set timeout_err, pulse done, -> IDLE.
REQ-027 digit_i_valid outside WAIT_RES ignored; no capture, no state change.
REQ-028 REPORT: result_valid=1 for one cycle with result_idx=image index; if index=NUM_IMAGES-1 pulse done same cycle and -> IDLE, else increment index, -> STREAM.
REQ-029 Address never exceeds NUM_IMAGES*784-1; no wrap within a run; next run restarts at 0.
REQ-030 result_digit/result_idx hold last captured values until next REPORT.

Reset
REQ-031 rst=0 at clock edge: state IDLE, all counters 0, img_rd_en, pixel_o_valid, result_valid, done, busy, timeout_err = 0; pixel_o, result_digit, result_idx = 0.
REQ-032 Reset mid-STREAM or mid-WAIT_RES aborts with no further pixels, results or done pulse.

Structure
REQ-033 Shared package holds state enum, PIX_PER_IMG=784, IMG_DIM=28.
REQ-034 One sub-module: stream_timeout_ctr (load/enable/terminal-count counter) used for gap pacing and timeout.

Verification
REQ-035 NUM_IMAGES=2, PIX_GAP=0, memory=address low byte, CNN model answers 7 then 3 after 100 cycles -> 1568 pixels back-to-back, results (idx0,7),(idx1,3), one done.
REQ-036 PIX_GAP=2 -> pixel_o_valid exactly every 3rd cycle, 784 per image, addresses 0..783 ascending.
REQ-037 No digit_i_valid, TIMEOUT_CYCLES=50 -> done after 50 cycles in WAIT_RES, timeout_err=1, no result_valid; next start clears it.
REQ-038 Spurious digit_i_valid=1 during STREAM -> ignored; later valid digit 5 reported.
REQ-039 rst=0 at pixel 400 -> all outputs 0 next cycle, IDLE; fresh start restarts at address 0.
REQ-040 start pulsed while busy -> no restart, address sequence unchanged.
